// File: rtl/cubehash_pkg.sv
// Shared constants and state encoding for the CubeHash host-port responder.
package cubehash_pkg;

  localparam int unsigned IO_W          = 16;
  localparam int unsigned BLK_W         = 256;
  localparam int unsigned DIG_W         = 512;
  localparam int unsigned WORDS_PER_BLK = BLK_W / IO_W;
  localparam int unsigned WORDS_PER_DIG = DIG_W / IO_W;

  localparam int unsigned WCNT_W = 4;
  localparam int unsigned DCNT_W = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BLK_WAIT = 3'd1,
    FIN_WAIT = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/cubehash_dig_shreg.sv
// 512-bit digest register: parallel load from the core, 16-bit words
// shifted out from the top. Clear has priority over load over shift.
module cubehash_dig_shreg
  import cubehash_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic             sh_i,
  input  logic [DIG_W-1:0] din_i,
  output logic [IO_W-1:0]  top_o
);

  logic [DIG_W-1:0] shreg_q;

  // Digest capture and word-by-word left shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else if (clr_i) begin
      shreg_q <= '0;
    end else if (ld_i) begin
      shreg_q <= din_i;
    end else if (sh_i) begin
      shreg_q <= shreg_q << IO_W;
    end
  end

  assign top_o = shreg_q[DIG_W-1 -: IO_W];

endmodule

// File: rtl/cubehash_io_resp.sv
// Host-port responder: packs 16-bit loads into 256-bit blocks for the
// round core, triggers finalization on the first fetch and streams the
// 512-bit digest back one 16-bit word per acknowledged fetch.
module cubehash_io_resp
  import cubehash_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             load,
  input  logic             fetch,
  input  logic [IO_W-1:0]  idata,
  output logic             ack,
  output logic [IO_W-1:0]  odata,
  output logic             err,
  output logic             core_init,
  output logic             core_blk_valid,
  output logic [BLK_W-1:0] core_blk,
  input  logic             core_ready,
  output logic             core_final,
  input  logic             core_dig_valid,
  input  logic [DIG_W-1:0] core_dig
);

  state_e              state_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [BLK_W-1:0]    blk_q;
  logic                ack_q;
  logic [IO_W-1:0]     odata_q;
  logic                err_q;
  logic                core_init_q;
  logic                blk_valid_q;
  logic                final_q;

  logic                ld_req;
  logic                fe_req;
  logic                both_req;
  logic [7:0]          blk_shamt;
  logic [BLK_W-1:0]    word_mask;
  logic [BLK_W-1:0]    word_data;
  logic                sh_clr;
  logic                sh_ld;
  logic                sh_shift;
  logic [IO_W-1:0]     sh_top;

  // Request qualification: a request is only seen when no ack was driven
  // last cycle, so a held request is serviced at most every other cycle.
  // The word slot is placed with shifts rather than a variable part-select.
  always_comb begin
    ld_req    = !ack_q && load && !fetch;
    fe_req    = !ack_q && fetch && !load;
    both_req  = !ack_q && load && fetch;
    blk_shamt = 8'(wcnt_q) * 8'(IO_W);
    word_mask = {{IO_W{1'b1}}, {(BLK_W-IO_W){1'b0}}} >> blk_shamt;
    word_data = {idata, {(BLK_W-IO_W){1'b0}}} >> blk_shamt;
    sh_clr    = init;
    sh_ld     = !init && (state_q == FIN_WAIT) && core_dig_valid;
    sh_shift  = !init && !both_req && (state_q == DRAIN) && fe_req;
  end

  cubehash_dig_shreg u_dig_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sh_clr),
    .ld_i  (sh_ld),
    .sh_i  (sh_shift),
    .din_i (core_dig),
    .top_o (sh_top)
  );

  // Protocol FSM, block packer, counters and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      dcnt_q      <= '0;
      blk_q       <= '0;
      ack_q       <= 1'b0;
      odata_q     <= '0;
      err_q       <= 1'b0;
      core_init_q <= 1'b0;
      blk_valid_q <= 1'b0;
      final_q     <= 1'b0;
    end else begin
      ack_q       <= 1'b0;
      core_init_q <= 1'b0;
      blk_valid_q <= 1'b0;
      final_q     <= 1'b0;
      if (init) begin
        state_q     <= IDLE;
        wcnt_q      <= '0;
        dcnt_q      <= '0;
        blk_q       <= '0;
        err_q       <= 1'b0;
        core_init_q <= 1'b1;
      end else if (both_req) begin
        err_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (ld_req) begin
              blk_q  <= (blk_q & ~word_mask) | word_data;
              wcnt_q <= wcnt_q + 4'd1;
              ack_q  <= 1'b1;
              if (wcnt_q == '1) state_q <= BLK_WAIT;
            end else if (fe_req) begin
              if (wcnt_q == '0) begin
                final_q <= 1'b1;
                state_q <= FIN_WAIT;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          BLK_WAIT: begin
            // Loads are silently held off here; only a fetch is an error.
            if (fe_req) err_q <= 1'b1;
            if (core_ready) begin
              blk_valid_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
          FIN_WAIT: begin
            if (ld_req) err_q <= 1'b1;
            if (core_dig_valid) begin
              dcnt_q  <= '0;
              state_q <= DRAIN;
            end
          end
          DRAIN: begin
            if (ld_req) begin
              err_q <= 1'b1;
            end else if (fe_req) begin
              odata_q <= sh_top;
              dcnt_q  <= dcnt_q + 5'd1;
              ack_q   <= 1'b1;
              if (dcnt_q == '1) state_q <= DONE;
            end
          end
          DONE: begin
            if (ld_req || fe_req) err_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ack            = ack_q;
  assign odata          = odata_q;
  assign err            = err_q;
  assign core_init      = core_init_q;
  assign core_blk_valid = blk_valid_q;
  assign core_blk       = blk_q;
  assign core_final     = final_q;

endmodule

// File: tb/tb_cubehash_io_resp.sv
// Directed self-checking bench for the CubeHash host-port responder.
module tb_cubehash_io_resp;
  import cubehash_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             init = 1'b0;
  logic             load = 1'b0;
  logic             fetch = 1'b0;
  logic [IO_W-1:0]  idata = '0;
  logic             ack;
  logic [IO_W-1:0]  odata;
  logic             err;
  logic             core_init;
  logic             core_blk_valid;
  logic [BLK_W-1:0] core_blk;
  logic             core_ready = 1'b0;
  logic             core_final;
  logic             core_dig_valid = 1'b0;
  logic [DIG_W-1:0] core_dig = '0;

  int n_cmp = 0;
  int n_err = 0;
  int n_ack = 0;
  int n_bv  = 0;
  int n_fin = 0;
  int a0, b0, f0;
  logic [BLK_W-1:0] exp_blk;

  cubehash_io_resp dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .init           (init),
    .load           (load),
    .fetch          (fetch),
    .idata          (idata),
    .ack            (ack),
    .odata          (odata),
    .err            (err),
    .core_init      (core_init),
    .core_blk_valid (core_blk_valid),
    .core_blk       (core_blk),
    .core_ready     (core_ready),
    .core_final     (core_final),
    .core_dig_valid (core_dig_valid),
    .core_dig       (core_dig)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge clk) begin
    if (ack) n_ack++;
    if (core_blk_valid) n_bv++;
    if (core_final) n_fin++;
  end

  task automatic chk(input string tag, input logic [DIG_W-1:0] obs, input logic [DIG_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [IO_W-1:0] v);
    load  = 1'b1;
    idata = v;
    tick();
    chk("load_ack", ack, 1'b1);
    load = 1'b0;
    tick();
  endtask

  task automatic fetch_word(input logic [IO_W-1:0] v);
    fetch = 1'b1;
    tick();
    chk("drain_ack", ack, 1'b1);
    chk("drain_word", odata, v);
    fetch = 1'b0;
    tick();
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_ack", ack, 1'b0);
    chk("rst_odata", odata, 16'h0000);
    chk("rst_err", err, 1'b0);
    chk("rst_blk", core_blk, {BLK_W{1'b0}});
    chk("rst_bv", core_blk_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    // init -> core_init one cycle later
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_pulse", core_init, 1'b1);
    chk("init_ack", ack, 1'b0);
    tick();
    chk("init_pulse_end", core_init, 1'b0);
    chk("init_err", err, 1'b0);
    chk("init_odata", odata, 16'h0000);

    // Full block 0x0001..0x0010 with core ready
    core_ready = 1'b1;
    a0 = n_ack;
    b0 = n_bv;
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin
      load_word(16'(i + 1));
      exp_blk = {exp_blk[BLK_W-IO_W-1:0], 16'(i + 1)};
    end
    tick();
    tick();
    chk("blk1_acks", n_ack - a0, 16);
    chk("blk1_valid_cnt", n_bv - b0, 1);
    chk("blk1_data", core_blk, exp_blk);

    // Load held 4 cycles -> two accepts into words 0 and 1
    a0 = n_ack;
    load  = 1'b1;
    idata = 16'hA5A5;
    repeat (4) tick();
    load = 1'b0;
    tick();
    tick();
    chk("held_acks", n_ack - a0, 2);
    chk("held_words", core_blk[255:208], 48'hA5A5_A5A5_0003);

    // Fetch on a partial block (wcnt=3)
    load_word(16'h3333);
    a0 = n_ack;
    f0 = n_fin;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    tick();
    chk("partial_err", err, 1'b1);
    chk("partial_noack", n_ack - a0, 0);
    chk("partial_nofinal", n_fin - f0, 0);
    pulse_init();
    chk("init_clr_err", err, 1'b0);
    chk("init_clr_blk", core_blk, {BLK_W{1'b0}});
    load_word(16'h1111);
    chk("init_clr_wcnt", core_blk, {16'h1111, {(BLK_W-IO_W){1'b0}}});

    // load and fetch together
    a0 = n_ack;
    load  = 1'b1;
    fetch = 1'b1;
    idata = 16'h7777;
    tick();
    load  = 1'b0;
    fetch = 1'b0;
    tick();
    tick();
    chk("lf_err", err, 1'b1);
    chk("lf_noack", n_ack - a0, 0);
    chk("lf_blk", core_blk, {16'h1111, {(BLK_W-IO_W){1'b0}}});
    pulse_init();

    // Block with core stalled; 17th load waits for the hand-off
    core_ready = 1'b0;
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin
      load_word(16'h0100 + 16'(i));
      exp_blk = {exp_blk[BLK_W-IO_W-1:0], 16'h0100 + 16'(i)};
    end
    a0 = n_ack;
    b0 = n_bv;
    load  = 1'b1;
    idata = 16'hBEEF;
    repeat (10) tick();
    chk("stall_noack", n_ack - a0, 0);
    chk("stall_nobv", n_bv - b0, 0);
    core_ready = 1'b1;
    tick();
    chk("stall_bv", core_blk_valid, 1'b1);
    chk("stall_ack_late", ack, 1'b0);
    chk("stall_blk", core_blk, exp_blk);
    tick();
    chk("w17_ack", ack, 1'b1);
    chk("w17_word", core_blk[255:240], 16'hBEEF);
    load = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) load_word(16'h0200 + 16'(i));
    tick();
    tick();

    // Finalization and full digest drain
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("fin_pulse", core_final, 1'b1);
    chk("fin_noack", ack, 1'b0);
    repeat (3) tick();
    for (int i = 0; i < 32; i++) core_dig = {core_dig[DIG_W-IO_W-1:0], 16'(i)};
    core_dig_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 32; i++) fetch_word(16'(i));
    a0 = n_ack;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    tick();
    chk("ovf_noack", n_ack - a0, 0);
    chk("ovf_err", err, 1'b1);
    chk("ovf_hold", odata, 16'h001F);

    // Reset in the middle of a drain
    pulse_init();
    for (int i = 0; i < 16; i++) load_word(16'h0300 + 16'(i));
    tick();
    tick();
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) fetch_word(16'(i));
    fetch = 1'b1;
    tick();
    chk("pre_rst_ack", ack, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_odata", odata, 16'h0000);
    chk("mid_rst_err", err, 1'b0);
    fetch = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
